// File: rtl/clk_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_cfg_pkg : shared types and widths for the clock/ADC bring-up FSM |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package clk_cfg_pkg;

  localparam int c_CNT_W   = 32;
  localparam int c_RETRY_W = 4;

  // Codes double as the state_dbg output value.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CDCE_RST  = 4'd1,
    ST_CDCE_CFG  = 4'd2,
    ST_LOCK_WAIT = 4'd3,
    ST_SETTLE    = 4'd4,
    ST_ADC_CFG   = 4'd5,
    ST_READY     = 4'd6,
    ST_RETRY     = 4'd7,
    ST_FAIL      = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for asynchronous level inputs       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/clk_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_cfg_sequencer : CDCE62005 + ADC bring-up with bounded retries    |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module clk_cfg_sequencer
  import clk_cfg_pkg::*;
#(
  parameter int GAP_CYCLES    = 64,
  parameter int CFG_TIMEOUT   = 100000,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       cdce_en,
  input  logic       cdce_cfg_finish,
  input  logic       pll_lock,
  output logic       adc_cfg_start,
  input  logic       adc_cfg_done,
  output logic       busy,
  output logic       board_ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [3:0] state_dbg
);

  localparam logic [c_CNT_W-1:0]   c_GAP_LAST    = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]   c_CFG_LAST    = c_CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0]   c_LOCK_LAST   = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0]   c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_RETRY_W-1:0] c_MAX_RETRY   = c_RETRY_W'(MAX_RETRY);

  state_t               r_state;
  state_t               w_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_RETRY_W-1:0] r_retry;
  logic                 w_lock_s;
  logic                 w_timed;
  logic                 w_cdce_en;
  logic                 w_busy;
  logic                 w_ready;
  logic                 w_fail;
  logic                 w_adc_start;
  logic                 r_cdce_en;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_fail;
  logic                 r_adc_start;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_lock),
    .o_q (w_lock_s)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Done/lock conditions are tested before the matching timeout.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:      if (start) w_next = ST_CDCE_RST;
      ST_CDCE_RST:  if (r_cnt == c_GAP_LAST) w_next = ST_CDCE_CFG;
      ST_CDCE_CFG: begin
        if (!cdce_cfg_finish)         w_next = ST_LOCK_WAIT;
        else if (r_cnt == c_CFG_LAST) w_next = ST_RETRY;
      end
      ST_LOCK_WAIT: begin
        if (w_lock_s)                  w_next = ST_SETTLE;
        else if (r_cnt == c_LOCK_LAST) w_next = ST_RETRY;
      end
      ST_SETTLE: begin
        if (!w_lock_s)                   w_next = ST_RETRY;
        else if (r_cnt == c_SETTLE_LAST) w_next = ST_ADC_CFG;
      end
      ST_ADC_CFG: begin
        if (adc_cfg_done && (r_cnt != '0)) w_next = ST_READY;
        else if (r_cnt == c_CFG_LAST)      w_next = ST_FAIL;
      end
      ST_READY:     if (!w_lock_s) w_next = ST_CDCE_RST;
      ST_RETRY:     w_next = (r_retry < c_MAX_RETRY) ? ST_CDCE_RST : ST_FAIL;
      ST_FAIL:      if (start) w_next = ST_CDCE_RST;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line
  // up with the state register while carrying no input-to-output path.
  always_comb begin
    w_timed     = (r_state == ST_CDCE_RST) || (r_state == ST_CDCE_CFG) ||
                  (r_state == ST_LOCK_WAIT) || (r_state == ST_SETTLE) ||
                  (r_state == ST_ADC_CFG);
    w_cdce_en   = !((w_next == ST_IDLE) || (w_next == ST_CDCE_RST) || (w_next == ST_FAIL));
    w_busy      = !((w_next == ST_IDLE) || (w_next == ST_READY) || (w_next == ST_FAIL));
    w_ready     = (w_next == ST_READY);
    w_fail      = (w_next == ST_FAIL);
    w_adc_start = (w_next == ST_ADC_CFG) && (r_state != ST_ADC_CFG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_retry     <= '0;
      r_cdce_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_adc_start <= 1'b0;
    end else begin
      if ((w_next != r_state) || !w_timed) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + 1'b1;

      if ((r_state == ST_RETRY) && (w_next == ST_CDCE_RST))
        r_retry <= r_retry + 1'b1;
      else if (w_next == ST_CDCE_RST &&
               ((r_state == ST_IDLE) || (r_state == ST_READY) || (r_state == ST_FAIL)))
        r_retry <= '0;

      r_cdce_en   <= w_cdce_en;
      r_busy      <= w_busy;
      r_ready     <= w_ready;
      r_fail      <= w_fail;
      r_adc_start <= w_adc_start;
    end
  end

  assign cdce_en       = r_cdce_en;
  assign busy          = r_busy;
  assign board_ready   = r_ready;
  assign fail          = r_fail;
  assign adc_cfg_start = r_adc_start;
  assign retry_cnt     = r_retry;
  assign state_dbg     = r_state;

endmodule
`default_nettype wire

// File: doc/clk_cfg_sequencer.md
# clk_cfg_sequencer

Board bring-up controller for the CDCE62005 clock-chip config engine and the downstream ADC configuration.
- On `start`, it holds the clock-chip engine in reset, enables it, waits for its active-low finish flag, then waits for PLL lock and a settle interval.
- It then triggers ADC configuration and asserts `board_ready`.
- Timeouts and lock loss trigger bounded retries; exhausting the retries ends in a sticky `fail`.
- It sits between the top-level reset/control logic and the clock-chip/ADC config engines.

## Interface
Parameters:
- `GAP_CYCLES`, 64: cycles `cdce_en` is held low before each config attempt.
- `CFG_TIMEOUT`, 100000: maximum cycles allowed for clock-chip config and for ADC config.
- `LOCK_TIMEOUT`, 1000000: maximum cycles to wait for PLL lock.
- `SETTLE_CYCLES`, 1000: cycles lock must stay high before ADC config starts.
- `MAX_RETRY`, 3: number of retries allowed; must be ≤ 15.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request to begin bring-up. Honoured only in IDLE or FAIL.
- `cdce_en` out 1: enable to the clock-chip config engine. Low holds the engine in reset.
- `cdce_cfg_finish` in 1: clock-chip engine done flag, active-low.
- `pll_lock` in 1: clock-chip lock indicator. Asynchronous; synchronized internally.
- `adc_cfg_start` out 1: one-cycle pulse that starts ADC configuration.
- `adc_cfg_done` in 1: ADC configuration complete, active-high.
- `busy` out 1: high in every state except IDLE, READY and FAIL.
- `board_ready` out 1: high only in READY.
- `fail` out 1: sticky failure flag.
- `retry_cnt` out 4: number of retries consumed in the current bring-up.
- `state_dbg` out 4: current state code.

## Operation
- **Reset values:** all outputs 0; state IDLE; counter 0.
- **Lock synchronizer:** `pll_lock` passes through a 2-flop synchronizer to give `lock_s`. The FSM uses only `lock_s`.
- **Counter:** one 32-bit counter, cleared on every state entry and incremented each cycle in a timed state. A timed state lasts exactly P cycles when its exit is triggered by the counter reaching P−1.
- **States** (state_dbg code, behaviour):
  - IDLE (0): `start` → CDCE_RST, with `retry_cnt` cleared to 0.
  - CDCE_RST (1): `cdce_en`=0. Counter reaches `GAP_CYCLES`−1 → CDCE_CFG.
  - CDCE_CFG (2): `cdce_en`=1.
    - `cdce_cfg_finish`==0 → LOCK_WAIT.
    - Counter reaches `CFG_TIMEOUT`−1 → RETRY.
  - LOCK_WAIT (3): `cdce_en`=1.
    - `lock_s`==1 → SETTLE.
    - Counter reaches `LOCK_TIMEOUT`−1 → RETRY.
  - SETTLE (4):
    - `lock_s`==0 → RETRY.
    - Counter reaches `SETTLE_CYCLES`−1 → ADC_CFG.
  - ADC_CFG (5):
    - `adc_cfg_start` is high in the first cycle of the state only.
    - `adc_cfg_done` → READY.
    - Counter reaches `CFG_TIMEOUT`−1 → FAIL. This path does not retry.
    - `adc_cfg_done` is ignored in the cycle `adc_cfg_start` is high.
  - READY (6): `board_ready`=1. `lock_s`==0 → CDCE_RST, with `retry_cnt` cleared to 0.
  - RETRY (7): single-cycle state.
    - `retry_cnt` < `MAX_RETRY` → increment `retry_cnt`, go to CDCE_RST.
    - Otherwise → FAIL.
  - FAIL (8): `fail`=1 and `cdce_en`=0.
    - `start` → CDCE_RST, with `fail` cleared and `retry_cnt` cleared to 0.
- **`cdce_en` outside the states above:** low in IDLE, CDCE_RST and FAIL; high in all other states, including READY.
- **Simultaneous events:** the done or lock condition wins over a timeout in the same cycle.
- **`start` outside IDLE/FAIL:** ignored.
- **`rst` mid-operation:** returns to IDLE on the next edge. All outputs go to reset values, including `fail`.

## Timing
- **`cdce_en` gap:** after `start` is sampled in IDLE, `cdce_en` stays low for `GAP_CYCLES` cycles, then rises.
- **Lock latency:** a `pll_lock` rise is visible as `lock_s` 2 cycles later. SETTLE is entered 1 cycle after that.
- **ADC start:** `adc_cfg_start` is asserted the cycle after SETTLE expires.
- **Ready:** `board_ready` rises the cycle after `adc_cfg_done` is sampled.
- **Lock loss in READY:** `board_ready` falls 3 cycles after `pll_lock` falls (2 synchronizer cycles plus 1 state update).
- **Output registration:** all outputs are registered and decoded from state, with no combinational path from inputs.

## Structure
- **Package `clk_cfg_pkg`:**
  - State enum with the codes 0–8 above, which double as `state_dbg` values.
  - Counter width constant (32).
  - `retry_cnt` width constant (4).
- **Sub-module `sync_2ff`:** a reusable 2-flop synchronizer, instantiated for `pll_lock`.
- Everything else lives in one FSM plus counter.

## Test plan
Bench parameters: `GAP_CYCLES`=4, `CFG_TIMEOUT`=50, `LOCK_TIMEOUT`=100, `SETTLE_CYCLES`=10, `MAX_RETRY`=2.
- **Nominal bring-up:** `start`; finish flag low 20 cycles after `cdce_en` rises; lock high 5 cycles later; `adc_cfg_done` 3 cycles after `adc_cfg_start` → `cdce_en` low for 4 cycles, exactly one `adc_cfg_start` pulse, `board_ready`=1, `retry_cnt`=0.
- **Lock timeout with recovery:** lock never rises on attempts 1 and 2, rises on attempt 3 → `retry_cnt` reaches 2, then READY is reached.
- **Lock never rises:** → after 3 attempts, `fail`=1, `state_dbg`=8, `cdce_en`=0. A following `start` clears `fail` and restarts with `retry_cnt`=0.
- **Lock glitch in SETTLE:** lock drops low for 2 cycles during SETTLE → RETRY, `retry_cnt`=1, `cdce_en` falls for 4 cycles.
- **Lock loss in READY:** from READY, `pll_lock` drops → `board_ready` falls exactly 3 cycles later; re-config begins with `retry_cnt`=0.
- **Reset and ignored start:** `rst` asserted during CDCE_CFG → next cycle all outputs are 0 and state is IDLE. `start` pulsed during LOCK_WAIT has no effect.
